ifetch_ctrl: RTL and testbench

Instruction-fetch controller for the pipelined MIPS core. Owns the program counter and the IF/ID pipeline register, and drives the address of the combinational instruction memory. Applies hazard-unit stalls, branch redirects and flushes. Time-shares the instruction memory with a debug/loader read port through a req/ack handshake that steals one fetch slot per access.

---
 rtl/ifetch_ctrl.sv | 114 +++++++++++
 tb/tb_ifetch_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: PC, IF/ID register and a debug read port
// that borrows one instruction-memory slot per access.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_ack,
  output logic [31:0] dbg_data,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DBG   = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        ack_q, ack_d;
  logic [31:0] dbg_data_q, dbg_data_d;
  logic [31:0] pc_plus4;
  logic [31:0] tgt;
  logic        in_dbg;
  logic        unused_lsbs;

  assign pc_plus4    = pc_q + 32'd4;
  assign tgt         = {branch_target[31:2], 2'b00};
  assign in_dbg      = (state_q == DBG);
  assign unused_lsbs = ^{branch_target[1:0], dbg_addr[1:0]};

  assign imem_addr = in_dbg ? {dbg_addr[31:2], 2'b00} : pc_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (dbg_req) state_d = DBG;
      DBG:     state_d = ACK;
      ACK:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // The stolen slot holds the PC and feeds a bubble into IF/ID.
  always_comb begin
    pc_d       = pc_plus4;
    instr_d    = imem_data;
    pc4_d      = pc_plus4;
    valid_d    = 1'b1;
    ack_d      = (state_d == ACK);
    dbg_data_d = in_dbg ? imem_data : dbg_data_q;

    if (branch_taken)  pc_d = tgt;
    else if (stall)    pc_d = pc_q;
    else if (in_dbg)   pc_d = pc_q;

    if (flush || branch_taken) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (in_dbg) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign pc         = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
  assign dbg_ack    = ack_q;
  assign dbg_data   = dbg_data_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, branch_taken;
  logic [31:0] branch_target;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pc, m_instr, m_pc4, m_data;
  logic        m_valid, m_ack;
  int          m_slot;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:2]];

  ifetch_ctrl #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack), .dbg_data(dbg_data),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .pc(pc), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  task automatic clear_inputs;
    stall = 0; flush = 0; branch_taken = 0;
    branch_target = '0; dbg_req = 0; dbg_addr = '0;
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic apply_reset;
    clear_inputs();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clear_inputs();
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0);
    end
    checks++;
    if ({ifid_instr, ifid_pc4, ifid_valid} !== 65'h0) begin
      errors++; $display("FAIL reset_ifid got %h/%h/%b exp 0",
                         ifid_instr, ifid_pc4, ifid_valid);
    end
    checks++;
    if ({dbg_ack, dbg_data} !== 33'h0) begin
      errors++; $display("FAIL reset_dbg got %b/%h exp 0", dbg_ack, dbg_data);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ifid_instr !== mem[i] || pc !== 32'(4 * (i + 1))
          || ifid_valid !== 1'b1 || ifid_pc4 !== 32'(4 * (i + 1))) begin
        errors++;
        $display("FAIL run%0d got pc %h instr %h v %b exp pc %h instr %h v 1",
                 i, pc, ifid_instr, ifid_valid, 32'(4 * (i + 1)), mem[i]);
      end
    end
  endtask

  task automatic test_stall;
    apply_reset();
    tick(); tick();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (pc !== 32'h8 || ifid_instr !== 32'h20010001) begin
        errors++;
        $display("FAIL stall%0d got pc %h instr %h exp 8 20010001",
                 i, pc, ifid_instr);
      end
    end
    stall = 0;
    tick();
    checks++;
    if (pc !== 32'hC || ifid_instr !== 32'h20020005) begin
      errors++;
      $display("FAIL stall_resume got pc %h instr %h exp c 20020005",
               pc, ifid_instr);
    end
  endtask

  task automatic test_branch;
    apply_reset();
    tick();
    stall = 1; branch_taken = 1; branch_target = 32'h1E;
    tick();
    checks++;
    if (pc !== 32'h1C || ifid_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch got pc %h v %b exp 1c 0", pc, ifid_valid);
    end
    clear_inputs();
    tick();
    checks++;
    if (ifid_instr !== 32'h8C2A0014 || ifid_valid !== 1'b1
        || pc !== 32'h20 || ifid_pc4 !== 32'h20) begin
      errors++;
      $display("FAIL branch_next got instr %h v %b pc %h exp 8c2a0014 1 20",
               ifid_instr, ifid_valid, pc);
    end
  endtask

  task automatic test_wrap;
    apply_reset();
    branch_taken = 1; branch_target = 32'hFFFF_FFFF;
    tick();
    branch_taken = 0;
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_tgt got %h exp fffffffc", pc);
    end
    tick();
    checks++;
    if (pc !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1
        || ifid_instr !== mem[255]) begin
      errors++;
      $display("FAIL wrap got pc %h pc4 %h v %b instr %h exp 0 0 1 %h",
               pc, ifid_pc4, ifid_valid, ifid_instr, mem[255]);
    end
  endtask

  task automatic test_dbg;
    apply_reset();
    tick();
    dbg_req = 1; dbg_addr = 32'h0000_000B;
    tick();
    checks++;
    if (pc !== 32'h8 || ifid_valid !== 1'b1 || dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL dbg_req_edge got pc %h v %b ack %b exp 8 1 0",
               pc, ifid_valid, dbg_ack);
    end
    checks++;
    if (imem_addr !== 32'h8) begin
      errors++; $display("FAIL dbg_addr got %h exp 8", imem_addr);
    end
    tick();
    checks++;
    if (pc !== 32'h8 || ifid_valid !== 1'b0 || dbg_ack !== 1'b1
        || dbg_data !== 32'h20020005) begin
      errors++;
      $display("FAIL dbg_ack got pc %h v %b ack %b data %h exp 8 0 1 20020005",
               pc, ifid_valid, dbg_ack, dbg_data);
    end
    dbg_req = 0;
    tick();
    checks++;
    if (pc !== 32'hC || ifid_valid !== 1'b1 || dbg_ack !== 1'b0
        || dbg_data !== 32'h20020005 || ifid_instr !== 32'h20020005) begin
      errors++;
      $display("FAIL dbg_after got pc %h v %b ack %b data %h exp c 1 0 20020005",
               pc, ifid_valid, dbg_ack, dbg_data);
    end
  endtask

  task automatic test_back_to_back;
    int last, acks;
    bit seen_valid;
    apply_reset();
    dbg_req = 1; dbg_addr = 32'h10;
    last = -1; acks = 0; seen_valid = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (dbg_ack) begin
        if (last >= 0) begin
          checks++;
          if (i - last < 3 || !seen_valid) begin
            errors++;
            $display("FAIL b2b_gap got %0d valid %b exp >=3 1",
                     i - last, seen_valid);
          end
        end
        last = i; acks++; seen_valid = 0;
      end else if (ifid_valid) begin
        seen_valid = 1;
      end
    end
    dbg_req = 0;
    checks++;
    if (acks != 5) begin
      errors++; $display("FAIL b2b_count got %0d exp 5", acks);
    end
  endtask

  task automatic test_reset_in_dbg;
    int acks;
    apply_reset();
    tick();
    dbg_req = 1; dbg_addr = 32'h8;
    tick();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (pc !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0
        || ifid_pc4 !== 32'h0 || dbg_ack !== 1'b0 || dbg_data !== 32'h0
        || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rst_dbg got pc %h v %b ack %b data %h ia %h exp all 0",
               pc, ifid_valid, dbg_ack, dbg_data, imem_addr);
    end
    dbg_req = 0;
    @(negedge clk);
    rst_n = 1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dbg_ack) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL rst_dbg_ack got %0d exp 0", acks);
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_addr, word, n_pc;
    int n_slot;
    apply_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
    m_ack = 0; m_data = 0; m_slot = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      stall         = ($urandom_range(0, 4) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = $urandom;
      if (dbg_req && dbg_ack) dbg_req = 0;
      else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req  = 1;
        dbg_addr = $urandom;
      end
      #1;
      // slot 1 is the cycle the memory is lent to the debug port
      exp_addr = (m_slot == 1) ? (dbg_addr & ~32'h3) : m_pc;
      checks++;
      if (imem_addr !== exp_addr) begin
        errors++;
        $display("FAIL rnd_addr c%0d got %h exp %h", cyc, imem_addr, exp_addr);
      end
      word = mem[exp_addr[9:2]];
      if (branch_taken) n_pc = branch_target & ~32'h3;
      else if (stall || m_slot == 1) n_pc = m_pc;
      else n_pc = m_pc + 4;
      if (flush || branch_taken || (!stall && m_slot == 1)) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (!stall) begin
        m_instr = word; m_pc4 = m_pc + 4; m_valid = 1;
      end
      if (m_slot == 1) m_data = word;
      n_slot = (m_slot == 0) ? (dbg_req ? 1 : 0) : (m_slot == 1 ? 2 : 0);
      m_slot = n_slot;
      m_ack = (n_slot == 2);
      m_pc = n_pc;
      @(posedge clk);
      #1;
      checks++;
      if (pc !== m_pc || ifid_instr !== m_instr || ifid_pc4 !== m_pc4
          || ifid_valid !== m_valid || dbg_ack !== m_ack
          || dbg_data !== m_data) begin
        errors++;
        $display("FAIL rnd c%0d got pc %h i %h p4 %h v %b a %b d %h exp %h %h %h %b %b %h",
                 cyc, pc, ifid_instr, ifid_pc4, ifid_valid, dbg_ack, dbg_data,
                 m_pc, m_instr, m_pc4, m_valid, m_ack, m_data);
      end
    end
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h20030000;
    mem[1] = 32'h20010001;
    mem[2] = 32'h20020005;
    mem[7] = 32'h8C2A0014;
    rst_n = 1;
    clear_inputs();
    test_reset();
    test_stall();
    test_branch();
    test_wrap();
    test_dbg();
    test_back_to_back();
    test_reset_in_dbg();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
